// File: rtl/ibex_fpr_wb_sched.sv
// ibex_fpr_wb_sched
//
// Write-back scheduler for long-latency register writes. It tracks which
// destination registers have a result outstanding, steers decode away from
// reading them, picks one of two result sources (FPU / LSU) per cycle
// round-robin, and drives a single registered write port into the register
// file.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   issue_valid_i/issue_rd_i       long-latency op issuing to a destination
//   issue_ready_o                  issue accepted this cycle
//   fpu_valid_i/rd/wdata, fpu_ready_o   FPU result channel
//   lsu_valid_i/rd/wdata, lsu_ready_o   load result channel
//   raddr_a/b/c_i, ren_i           decode read ports and their enables
//   hazard_o                       an enabled read targets a pending register
//   rf_we_o/rf_waddr_o/rf_wdata_o  register-file write port (1-cycle latency)
//   idle_o                         nothing outstanding and nothing in flight
module ibex_fpr_wb_sched #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          ZeroReg0       = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    output logic                 issue_ready_o,
    input  logic                 fpu_valid_i,
    input  logic [4:0]           fpu_rd_i,
    input  logic [DataWidth-1:0] fpu_wdata_i,
    output logic                 fpu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [4:0]           raddr_c_i,
    input  logic [2:0]           ren_i,
    output logic                 hazard_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 idle_o
);

    localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);

    // Saturating up/down counter step; simultaneous inc and dec cancel.
    function automatic logic [2:0] cnt_sat(input logic [2:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
        logic [2:0] res;
        res = cnt;
        if (inc && !dec && (cnt < MaxCnt)) begin
            res = cnt + 3'd1;
        end else if (dec && !inc && (cnt != 3'd0)) begin
            res = cnt - 3'd1;
        end
        return res;
    endfunction

    logic [31:0]          busy_q;
    logic [31:0]          busy_d;
    logic [2:0]           cnt_q;
    logic                 prio_q;

    // Write stage: vld_p1 marks any accepted result (including x0 writes that
    // are suppressed), we_p1 is the actual register-file write strobe.
    logic                 vld_p1;
    logic                 we_p1;
    logic [4:0]           waddr_p1;
    logic [DataWidth-1:0] wdata_p1;

    logic                 issue_hs;
    logic                 issue_tracked;
    logic                 gnt_fpu;
    logic                 gnt_lsu;
    logic                 acc_p0;
    logic [4:0]           acc_rd_p0;
    logic [DataWidth-1:0] acc_data_p0;
    logic                 acc_we_p0;

    // ---- Stage 0: issue check, source arbitration ----
    assign issue_ready_o = !busy_q[issue_rd_i] && (cnt_q < MaxCnt);
    assign issue_hs      = issue_valid_i && issue_ready_o;
    assign issue_tracked = issue_hs && !(ZeroReg0 && (issue_rd_i == 5'd0));

    assign gnt_fpu = fpu_valid_i && (!lsu_valid_i || !prio_q);
    assign gnt_lsu = lsu_valid_i && (!fpu_valid_i || prio_q);

    assign fpu_ready_o = gnt_fpu;
    assign lsu_ready_o = gnt_lsu;

    assign acc_p0      = gnt_fpu || gnt_lsu;
    assign acc_rd_p0   = gnt_fpu ? fpu_rd_i : lsu_rd_i;
    assign acc_data_p0 = gnt_fpu ? fpu_wdata_i : lsu_wdata_i;
    assign acc_we_p0   = acc_p0 && !(ZeroReg0 && (acc_rd_p0 == 5'd0));

    // Commit clears first so a same-edge re-issue of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (we_p1) begin
            busy_d[waddr_p1] = 1'b0;
        end
        if (issue_tracked) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    always_comb begin
        hazard_o = (ren_i[0] && busy_q[raddr_a_i]) ||
                   (ren_i[1] && busy_q[raddr_b_i]) ||
                   (ren_i[2] && busy_q[raddr_c_i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            prio_q   <= 1'b0;
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_sat(cnt_q, issue_hs, vld_p1);
            if (gnt_fpu) begin
                prio_q <= 1'b1;
            end else if (gnt_lsu) begin
                prio_q <= 1'b0;
            end
            // ---- Stage 1: registered write port ----
            vld_p1 <= acc_p0;
            we_p1  <= acc_we_p0;
            if (acc_p0) begin
                waddr_p1 <= acc_rd_p0;
                wdata_p1 <= acc_data_p0;
            end
        end
    end

    assign rf_we_o    = we_p1;
    assign rf_waddr_o = waddr_p1;
    assign rf_wdata_o = wdata_p1;
    assign idle_o     = (cnt_q == 3'd0) && !we_p1;

endmodule

// File: tb/tb_ibex_fpr_wb_sched.sv
// Self-checking bench for ibex_fpr_wb_sched. Expected register-file writes
// are queued when a result is accepted and compared when rf_we_o pulses.
module tb_ibex_fpr_wb_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_ready_o;
    logic        fpu_valid_i = 1'b0;
    logic [4:0]  fpu_rd_i = '0;
    logic [31:0] fpu_wdata_i = '0;
    logic        fpu_ready_o;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_rd_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_ready_o;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;
    logic [4:0]  raddr_c_i = '0;
    logic [2:0]  ren_i = '0;
    logic        hazard_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        idle_o;

    ibex_fpr_wb_sched #(
        .DataWidth     (32),
        .MaxOutstanding(4),
        .ZeroReg0      (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_valid_i(issue_valid_i),
        .issue_rd_i   (issue_rd_i),
        .issue_ready_o(issue_ready_o),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_rd_i     (fpu_rd_i),
        .fpu_wdata_i  (fpu_wdata_i),
        .fpu_ready_o  (fpu_ready_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_ready_o  (lsu_ready_o),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .raddr_c_i    (raddr_c_i),
        .ren_i        (ren_i),
        .hazard_o     (hazard_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .idle_o       (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic m_prio = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Write-port monitor: every pulse must match the oldest queued write.
    always @(negedge clk_i) begin
        if (rst_ni && rf_we_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(rf_waddr_o), 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(rf_waddr_o), 64'(e.addr));
                check("wb_data", 64'(rf_wdata_o), 64'(e.data));
            end
        end
    end

    task automatic do_reset();
        rst_ni        = 1'b0;
        issue_valid_i = 1'b0;
        fpu_valid_i   = 1'b0;
        lsu_valid_i   = 1'b0;
        exp_q.delete();
        m_prio = 1'b0;
        #1;
        check("rst_we", 64'(rf_we_o), 64'd0);
        check("rst_waddr", 64'(rf_waddr_o), 64'd0);
        check("rst_wdata", 64'(rf_wdata_o), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_hazard", 64'(hazard_o), 64'd0);
        check("rst_ready", 64'(issue_ready_o), 64'd1);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        #1;
        check("issue_ready", 64'(issue_ready_o), 64'd1);
        step();
        issue_valid_i = 1'b0;
    endtask

    task automatic drive_result(input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        logic ef, el;
        wr_t  w;
        fpu_valid_i = fv; fpu_rd_i = frd; fpu_wdata_i = fd;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_wdata_i = ld;
        #1;
        ef = fv && (!lv || !m_prio);
        el = lv && (!fv || m_prio);
        check("fpu_ready", 64'(fpu_ready_o), 64'(ef));
        check("lsu_ready", 64'(lsu_ready_o), 64'(el));
        if (ef) begin
            w.addr = frd; w.data = fd;
            if (frd != 5'd0) exp_q.push_back(w);
            m_prio = 1'b1;
        end else if (el) begin
            w.addr = lrd; w.data = ld;
            if (lrd != 5'd0) exp_q.push_back(w);
            m_prio = 1'b0;
        end
        step();
        fpu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
    endtask

    initial begin
        // Single FPU op: hazard tracking across issue and commit.
        do_reset();
        raddr_a_i = 5'd5; ren_i = 3'b001;
        #1 check("s1_haz_pre", 64'(hazard_o), 64'd0);
        issue(5'd5);
        check("s1_haz_c1", 64'(hazard_o), 64'd1);
        check("s1_idle_busy", 64'(idle_o), 64'd0);
        repeat (2) begin
            step();
            check("s1_haz_wait", 64'(hazard_o), 64'd1);
        end
        drive_result(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check("s1_we", 64'(rf_we_o), 64'd1);
        check("s1_haz_we", 64'(hazard_o), 64'd1);
        step();
        check("s1_haz_post", 64'(hazard_o), 64'd0);
        check("s1_we_post", 64'(rf_we_o), 64'd0);
        check("s1_idle", 64'(idle_o), 64'd1);

        // Both sources valid four cycles: strict alternation FPU first.
        do_reset();
        ren_i = 3'b000;
        for (int i = 0; i < 4; i++) begin
            drive_result(1'b1, 5'd10, 32'hF000_0000 + 32'(i),
                         1'b1, 5'd11, 32'h1000_0000 + 32'(i));
        end
        step();
        check("s2_idle", 64'(idle_o), 64'd1);

        // Outstanding limit.
        do_reset();
        for (int r = 1; r <= 4; r++) issue(5'(r));
        issue_rd_i = 5'd6;
        #1 check("s3_full", 64'(issue_ready_o), 64'd0);
        drive_result(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h0000_1111);
        check("s3_full_we", 64'(issue_ready_o), 64'd0);
        step();
        check("s3_room", 64'(issue_ready_o), 64'd1);
        issue_rd_i = 5'd2;
        #1 check("s3_busy_rd", 64'(issue_ready_o), 64'd0);
        for (int r = 2; r <= 4; r++) drive_result(1'b1, 5'(r), 32'hA5A5_0000 + 32'(r), 1'b0, 5'd0, 32'h0);
        step();
        check("s3_idle", 64'(idle_o), 64'd1);

        // x0 is never tracked or written but still counted.
        do_reset();
        raddr_a_i = 5'd0; raddr_b_i = 5'd0; raddr_c_i = 5'd0; ren_i = 3'b111;
        issue(5'd0);
        check("s4_haz", 64'(hazard_o), 64'd0);
        check("s4_idle_pend", 64'(idle_o), 64'd0);
        drive_result(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD0_BAD0);
        check("s4_we", 64'(rf_we_o), 64'd0);
        check("s4_haz2", 64'(hazard_o), 64'd0);
        step();
        check("s4_idle", 64'(idle_o), 64'd1);

        // Same-edge clear/set of x7, then reset with a result in flight.
        do_reset();
        raddr_a_i = 5'd7; raddr_b_i = 5'd3; ren_i = 3'b001;
        issue(5'd3);
        drive_result(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_0001);
        check("s5_we", 64'(rf_we_o), 64'd1);
        issue(5'd7);
        check("s5_busy7", 64'(hazard_o), 64'd1);
        check("s5_cnt_hold", 64'(idle_o), 64'd0);
        issue_rd_i = 5'd7;
        #1 check("s5_rd7_blk", 64'(issue_ready_o), 64'd0);
        drive_result(1'b1, 5'd7, 32'h7777_0002, 1'b0, 5'd0, 32'h0);
        do_reset();
        ren_i = 3'b011;
        repeat (3) step();
        check("s5_haz_clr", 64'(hazard_o), 64'd0);
        check("s5_idle", 64'(idle_o), 64'd1);
        check("s5_no_we", 64'(rf_we_o), 64'd0);
        issue_rd_i = 5'd7;
        #1 check("s5_ready7", 64'(issue_ready_o), 64'd1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
